// File: rtl/pokey_pkg.sv
// Shared types and constants for the POKEY keyboard/paddle responder.
package pokey_pkg;

   localparam int unsigned POT_MAX_DEFAULT = 228;
   localparam int unsigned KEY_W           = 4;
   localparam int unsigned NUM_KEYS        = 1 << KEY_W;
   localparam int unsigned SEEN_W          = 2;

   typedef enum logic [1:0] {
      POT_DUMP   = 2'd0,
      POT_CHARGE = 2'd1,
      POT_DONE   = 2'd2
   } pot_state_e;

   function automatic logic [7:0] clamp_pot(input logic [7:0] value, input logic [7:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/pot_channel.sv
// One paddle channel: models the RC charge time as a cycle count from dump release.
module pot_channel
   import pokey_pkg::*;
#(
   parameter int unsigned POT_MAX = POT_MAX_DEFAULT
) (
   input  logic       o2,
   input  logic       rst_L,
   input  logic       rel,
   input  logic [7:0] paddle,
   output logic       scan_out
);

   localparam logic [7:0] LIMIT = 8'(POT_MAX);

   pot_state_e state_q;
   logic [7:0] count_q;
   logic [7:0] target_q;
   logic       scan_q;

   // Target is latched once on leaving DUMP; later paddle changes wait for the next dump.
   always_ff @(posedge o2 or negedge rst_L) begin
      if (!rst_L) begin
         state_q  <= POT_DUMP;
         count_q  <= '0;
         target_q <= '0;
         scan_q   <= 1'b0;
      end else if (rel) begin
         state_q  <= POT_DUMP;
         count_q  <= '0;
         scan_q   <= 1'b0;
      end else begin
         case (state_q)
            POT_DUMP: begin
               target_q <= clamp_pot(paddle, LIMIT);
               count_q  <= '0;
               state_q  <= POT_CHARGE;
            end
            POT_CHARGE: begin
               if (count_q >= target_q) begin
                  scan_q  <= 1'b1;
                  state_q <= POT_DONE;
               end else begin
                  count_q <= 8'(count_q + 8'd1);
               end
            end
            POT_DONE: scan_q <= 1'b1;
            default:  state_q <= POT_DUMP;
         endcase
      end
   end

   assign scan_out = scan_q;

endmodule

// File: rtl/pokey_input_emu.sv
// Device end of the POKEY key-scan and pot-scan interfaces, fed by host key events and paddle values.
module pokey_input_emu
   import pokey_pkg::*;
#(
   parameter int unsigned MIN_SCANS = 2,
   parameter int unsigned POT_MAX   = POT_MAX_DEFAULT
) (
   input  logic             o2,
   input  logic             rst_L,
   input  logic [KEY_W-1:0] key_scan_L,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key_code,
   input  logic             key_make,
   input  logic             shift_in,
   output logic             kr1_L,
   output logic             kr2_L,
   input  logic             pot_rel_0,
   input  logic             pot_rel_1,
   input  logic [7:0]       paddle0,
   input  logic [7:0]       paddle1,
   output logic [7:0]       pot_scan
);

   localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(MIN_SCANS);

   logic [NUM_KEYS-1:0]             pressed_q, pressed_d;
   logic [NUM_KEYS-1:0]             rel_pend_q, rel_pend_d;
   logic [NUM_KEYS-1:0][SEEN_W-1:0] seen_q, seen_d;
   logic                            kr2_q;
   logic [KEY_W-1:0]                scan_idx;
   logic                            accept;
   logic                            pot0, pot1;

   assign scan_idx  = ~key_scan_L;
   assign key_ready = rst_L;
   assign accept    = key_valid & key_ready;

   // Per-key update; the final resolve lets a release land on the same edge as the last needed hit.
   always_comb begin
      pressed_d  = pressed_q;
      rel_pend_d = rel_pend_q;
      seen_d     = seen_q;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
         if (pressed_q[k] && (scan_idx == KEY_W'(k)) && (seen_q[k] < SEEN_MAX))
            seen_d[k] = SEEN_W'(seen_q[k] + SEEN_W'(1));
         if (accept && (key_code == KEY_W'(k))) begin
            if (key_make) begin
               if (!pressed_q[k]) begin
                  pressed_d[k] = 1'b1;
                  seen_d[k]    = '0;
               end
               rel_pend_d[k] = 1'b0;
            end else if (pressed_q[k]) begin
               rel_pend_d[k] = 1'b1;
            end
         end
         if (pressed_d[k] && rel_pend_d[k] && (seen_d[k] == SEEN_MAX)) begin
            pressed_d[k]  = 1'b0;
            rel_pend_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge o2 or negedge rst_L) begin
      if (!rst_L) begin
         pressed_q  <= '0;
         rel_pend_q <= '0;
         seen_q     <= '0;
         kr2_q      <= 1'b1;
      end else begin
         pressed_q  <= pressed_d;
         rel_pend_q <= rel_pend_d;
         seen_q     <= seen_d;
         kr2_q      <= ~shift_in;
      end
   end

   // Return line follows the address combinationally so the controller sees it in the same cycle.
   assign kr1_L = ~pressed_q[scan_idx];
   assign kr2_L = kr2_q;

   pot_channel #(.POT_MAX(POT_MAX)) u_pot0 (
      .o2       (o2),
      .rst_L    (rst_L),
      .rel      (pot_rel_0),
      .paddle   (paddle0),
      .scan_out (pot0)
   );

   pot_channel #(.POT_MAX(POT_MAX)) u_pot1 (
      .o2       (o2),
      .rst_L    (rst_L),
      .rel      (pot_rel_1),
      .paddle   (paddle1),
      .scan_out (pot1)
   );

   assign pot_scan = {6'b0, pot1, pot0};

endmodule
